// File: rtl/mem_pkg.sv
// Shared memory-port definitions used by the processor, the arbiter and the memory model.
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Source tags stored in the arbiter's in-order response FIFO.
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  typedef struct packed {
    logic                  req_type;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response channel between a memory requester (master) and a memory port (slave).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // A request transfers on a cycle where req_val & req_rdy; the master holds val and
  // payload until then. Responses have no ready: resp_val is a one-cycle pulse.
  logic              req_val;
  logic              req_rdy;
  logic              req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_val;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_val, req_type, req_addr, req_wdata,
    input  req_rdy, resp_val, resp_data
  );

  modport slave (
    input  req_val, req_type, req_addr, req_wdata,
    output req_rdy, resp_val, resp_data
  );

endinterface

// File: rtl/arb_tag_fifo.sv
// Small FIFO of response source tags; push and pop may coincide, even when full.
module arb_tag_fifo
  import mem_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    do_pop  = pop & ~empty;
    // When full, the slot being freed by a same-cycle pop is the one written.
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (imem) and data (dmem): data wins by priority,
// fetch wins after STARVE_LIMIT denied cycles; responses return in issue order by tag.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter  int ADDR_W       = 32,
  parameter  int DATA_W       = 32,
  parameter  int DEPTH        = 2,
  parameter  int STARVE_LIMIT = 4,
  localparam int CNT_W        = $clog2(DEPTH) + 1,
  localparam int STV_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  mem_arbiter_if.slave       imem,
  mem_arbiter_if.slave       dmem,
  mem_arbiter_if.master      mem,
  output logic               err,
  output logic [CNT_W-1:0]   dbg_count,
  output logic [STV_W-1:0]   dbg_starve_cnt
);

  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  logic             can_issue;
  logic             grant_i, grant_d;
  logic             push, pop;
  logic             tag_in, tag_head;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             err_q, err_d;

  arb_tag_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (tag_in),
    .dout  (tag_head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // A response popping this cycle frees a slot for a request issued this cycle.
  always_comb begin
    can_issue = ~full | mem.resp_val;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    if (rst && can_issue) begin
      if (imem.req_val && (starve_q == STARVE_MAX)) begin
        grant_i = 1'b1;
      end else if (dmem.req_val) begin
        grant_d = 1'b1;
      end else if (imem.req_val) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    mem.req_val   = grant_i | grant_d;
    mem.req_type  = MEM_READ;
    mem.req_addr  = '0;
    mem.req_wdata = '0;
    if (grant_d) begin
      mem.req_type  = dmem.req_type;
      mem.req_addr  = dmem.req_addr;
      mem.req_wdata = dmem.req_wdata;
    end else if (grant_i) begin
      mem.req_addr  = imem.req_addr;
    end
    imem.req_rdy = grant_i & mem.req_rdy;
    dmem.req_rdy = grant_d & mem.req_rdy;
  end

  assign push   = mem.req_val & mem.req_rdy;
  assign tag_in = grant_d ? SRC_D : SRC_I;
  assign pop    = rst & mem.resp_val & ~empty;

  always_comb begin
    imem.resp_val  = pop & (tag_head == SRC_I);
    dmem.resp_val  = pop & (tag_head == SRC_D);
    imem.resp_data = '0;
    dmem.resp_data = '0;
    if (imem.resp_val) begin
      imem.resp_data = mem.resp_data;
    end
    if (dmem.resp_val) begin
      dmem.resp_data = mem.resp_data;
    end
  end

  always_comb begin
    err_d = err_q | (mem.resp_val & empty);
    if (!imem.req_val || (grant_i && mem.req_rdy)) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign err            = err_q;
  assign dbg_count      = count;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table plus an in-order response scoreboard.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int SL    = 4;

  logic       clk;
  logic       rst;
  logic       err;
  logic [1:0] dbg_count;
  logic [2:0] dbg_starve;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) imem_if ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dmem_if ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem_if),
    .dmem           (dmem_if),
    .mem            (mem_if),
    .err            (err),
    .dbg_count      (dbg_count),
    .dbg_starve_cnt (dbg_starve)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        dt;
    logic [31:0] da;
    logic [31:0] dw;
    logic        mrdy;
    logic        rv;
    logic [31:0] xd;
    logic        e_mval;
    logic        e_src;
    logic        e_irdy;
    logic        e_drdy;
    logic [1:0]  e_cnt;
    logic [2:0]  e_stv;
  } vec_t;

  vec_t          vecs[$];
  logic [DW:0]   exp_q[$];
  logic          err_exp;
  int            n_checks;
  int            n_fail;

  function automatic vec_t mk(logic iv, logic [31:0] ia, logic dv, logic dt, logic [31:0] da,
                              logic [31:0] dw, logic mrdy, logic rv, logic [31:0] xd,
                              logic e_mval, logic e_src, logic e_irdy, logic e_drdy,
                              logic [1:0] e_cnt, logic [2:0] e_stv);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dv = dv; v.dt = dt; v.da = da; v.dw = dw;
    v.mrdy = mrdy; v.rv = rv; v.xd = xd;
    v.e_mval = e_mval; v.e_src = e_src; v.e_irdy = e_irdy; v.e_drdy = e_drdy;
    v.e_cnt = e_cnt; v.e_stv = e_stv;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic drive_inputs(input logic iv, input logic [31:0] ia, input logic dv,
                              input logic dt, input logic [31:0] da, input logic [31:0] dw,
                              input logic mrdy, input logic rv, input logic [31:0] rdata);
    imem_if.req_val   = iv;
    imem_if.req_addr  = ia;
    imem_if.req_type  = MEM_READ;
    imem_if.req_wdata = '0;
    dmem_if.req_val   = dv;
    dmem_if.req_type  = dt;
    dmem_if.req_addr  = da;
    dmem_if.req_wdata = dw;
    mem_if.req_rdy    = mrdy;
    mem_if.resp_val   = rv;
    mem_if.resp_data  = rdata;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " memreq_val"},    mem_if.req_val, 0);
    check({tag, " memreq_type"},   mem_if.req_type, 0);
    check({tag, " memreq_addr"},   mem_if.req_addr, 0);
    check({tag, " memreq_wdata"},  mem_if.req_wdata, 0);
    check({tag, " imemreq_rdy"},   imem_if.req_rdy, 0);
    check({tag, " dmemreq_rdy"},   dmem_if.req_rdy, 0);
    check({tag, " imemresp_val"},  imem_if.resp_val, 0);
    check({tag, " dmemresp_val"},  dmem_if.resp_val, 0);
    check({tag, " imemresp_data"}, imem_if.resp_data, 0);
    check({tag, " dmemresp_data"}, dmem_if.resp_data, 0);
    check({tag, " err"},           err, 0);
    check({tag, " count"},         dbg_count, 0);
    check({tag, " starve_cnt"},    dbg_starve, 0);
  endtask

  // One cycle: drive at negedge, check combinational outputs, then registered state.
  task automatic run_vec(input vec_t v, input int idx);
    logic [DW:0] head;
    logic        want;
    logic [31:0] rdata;
    string       p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    want  = v.rv && (exp_q.size() > 0);
    rdata = want ? exp_q[0][DW-1:0] : 32'hBAD0_BAD0;
    drive_inputs(v.iv, v.ia, v.dv, v.dt, v.da, v.dw, v.mrdy, v.rv, rdata);
    #1;
    check({p, " memreq_val"},  mem_if.req_val, v.e_mval);
    check({p, " imemreq_rdy"}, imem_if.req_rdy, v.e_irdy);
    check({p, " dmemreq_rdy"}, dmem_if.req_rdy, v.e_drdy);
    if (v.e_mval) begin
      check({p, " memreq_addr"},  mem_if.req_addr, v.e_src ? v.da : v.ia);
      check({p, " memreq_type"},  mem_if.req_type, v.e_src ? v.dt : MEM_READ);
      check({p, " memreq_wdata"}, mem_if.req_wdata, v.e_src ? v.dw : 32'h0);
    end
    if (want) begin
      head = exp_q.pop_front();
      check({p, " imemresp_val"},  imem_if.resp_val, !head[DW]);
      check({p, " dmemresp_val"},  dmem_if.resp_val, head[DW]);
      check({p, " imemresp_data"}, imem_if.resp_data, head[DW] ? 32'h0 : head[DW-1:0]);
      check({p, " dmemresp_data"}, dmem_if.resp_data, head[DW] ? head[DW-1:0] : 32'h0);
    end else begin
      check({p, " imemresp_val"}, imem_if.resp_val, 0);
      check({p, " dmemresp_val"}, dmem_if.resp_val, 0);
      if (v.rv) err_exp = 1'b1;
    end
    if (v.e_mval && v.mrdy) exp_q.push_back({v.e_src, v.xd});
    @(posedge clk);
    #1;
    check({p, " count"},      dbg_count, v.e_cnt);
    check({p, " starve_cnt"}, dbg_starve, v.e_stv);
    check({p, " err"},        err, err_exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    err_exp  = 1'b0;

    // Reset held with requests and a response pending: every output must read zero.
    rst = 1'b0;
    drive_inputs(1, 32'h200, 1, MEM_WRITE, 32'h100, 32'hFFFF_FFFF, 1, 1, 32'h1234_5678);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    drive_inputs(0, 0, 0, 0, 0, 0, 1, 0, 0);

    //             iv  ia        dv dt da        dw            rdy rv xd            mv src ir dr cnt stv
    // lone fetch
    vecs.push_back(mk(1, 32'h200, 0, 0, 32'h0,   32'h0,        1, 0, 32'h00A00093, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        0, 0, 0, 0, 0, 0));
    // contention: D first, then I; responses D then I
    vecs.push_back(mk(1, 32'h204, 1, 1, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0000ACED, 1, 1, 0, 1, 1, 1));
    vecs.push_back(mk(1, 32'h204, 0, 0, 32'h0,   32'h0,        1, 1, 32'h00B00113, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        0, 0, 0, 0, 0, 0));
    // starvation: D D D D I D
    vecs.push_back(mk(1, 32'h300, 1, 0, 32'h400, 32'h0,        1, 0, 32'h11,       1, 1, 0, 1, 1, 1));
    vecs.push_back(mk(1, 32'h300, 1, 0, 32'h404, 32'h0,        1, 1, 32'h12,       1, 1, 0, 1, 1, 2));
    vecs.push_back(mk(1, 32'h300, 1, 0, 32'h408, 32'h0,        1, 1, 32'h13,       1, 1, 0, 1, 1, 3));
    vecs.push_back(mk(1, 32'h300, 1, 0, 32'h40C, 32'h0,        1, 1, 32'h14,       1, 1, 0, 1, 1, 4));
    vecs.push_back(mk(1, 32'h300, 1, 0, 32'h410, 32'h0,        1, 1, 32'h21,       1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 32'h304, 1, 0, 32'h410, 32'h0,        1, 1, 32'h15,       1, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        0, 0, 0, 0, 0, 0));
    // full FIFO: stall, same-cycle pop+push at count 2, saturation, starvation override
    vecs.push_back(mk(1, 32'h500, 1, 1, 32'h600, 32'hCAFE0001, 1, 0, 32'h31,       1, 1, 0, 1, 1, 1));
    vecs.push_back(mk(1, 32'h500, 1, 1, 32'h604, 32'hCAFE0002, 1, 0, 32'h32,       1, 1, 0, 1, 2, 2));
    vecs.push_back(mk(1, 32'h500, 1, 1, 32'h608, 32'hCAFE0003, 1, 0, 32'h0,        0, 0, 0, 0, 2, 3));
    vecs.push_back(mk(1, 32'h500, 1, 1, 32'h608, 32'hCAFE0003, 1, 1, 32'h33,       1, 1, 0, 1, 2, 4));
    vecs.push_back(mk(1, 32'h500, 1, 1, 32'h60C, 32'hCAFE0004, 1, 0, 32'h0,        0, 0, 0, 0, 2, 4));
    vecs.push_back(mk(1, 32'h500, 1, 1, 32'h60C, 32'hCAFE0004, 1, 1, 32'h41,       1, 0, 1, 0, 2, 0));
    vecs.push_back(mk(0, 32'h0,   1, 1, 32'h60C, 32'hCAFE0004, 1, 1, 32'h34,       1, 1, 0, 1, 2, 0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        0, 0, 0, 0, 0, 0));
    // memory stall: request offered, not accepted, then accepted
    vecs.push_back(mk(1, 32'h700, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'h700, 0, 0, 32'h0,   32'h0,        1, 0, 32'h51,       1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        0, 0, 0, 0, 0, 0));
    // spurious response: err set and held
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Async reset with one request outstanding, dropped between clock edges.
    @(negedge clk);
    drive_inputs(1, 32'h800, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check("async pre count", dbg_count, 1);
    #2;
    rst = 1'b0;
    drive_inputs(1, 32'h804, 1, MEM_WRITE, 32'h808, 32'h5555_AAAA, 1, 1, 32'h1234);
    #1;
    check_all_zero("async");
    exp_q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive_inputs(0, 0, 0, 0, 0, 0, 1, 0, 0);
    run_vec(mk(1, 32'h900, 0, 0, 32'h0, 32'h0, 1, 0, 32'h61, 1, 0, 1, 0, 1, 0), 100);
    run_vec(mk(0, 32'h0,   0, 0, 32'h0, 32'h0, 1, 1, 32'h0,  0, 0, 0, 0, 0, 0), 101);

    check("exp_q drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
